// File: rtl/y_row_sched_pkg.sv
// Shared y-path definitions: scheduler state encoding, the decoder
// "not yet valid" sentinel, the highest legal SRAM word index, and small
// helpers used by the row scheduler.
package y_row_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ARM   = 3'd2,
        ST_FETCH = 3'd3,
        ST_WAITD = 3'd4,
        ST_RESP  = 3'd5
    } yState_e;

    // Decoder output value meaning "address not yet resolved".
    localparam logic [10:0] ADDR_NONE = 11'h7FF;
    // Highest row-word index (row[15:4]) that maps to real SRAM.
    localparam logic [11:0] MAX_WORD  = 12'h7FE;

    // Row numbers whose word index lies beyond the SRAM are rejected.
    function automatic logic rowOutOfRange(input logic [15:0] row);
        return (row[15:4] > MAX_WORD);
    endfunction

    // Both decoder outputs have left the sentinel value.
    function automatic logic addrPairDone(input logic [10:0] a1,
                                          input logic [10:0] a2);
        return (a1 != ADDR_NONE) && (a2 != ADDR_NONE);
    endfunction

endpackage

// File: rtl/y_row_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   req[1:0]     : request vector
//   update       : advance the last-granted pointer to the current grant
//   grant[1:0]   : one-hot grant (combinational), zero when no request
// After reset the pointer names requester 1, so requester 0 wins the
// first tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic lastGrant_r;

    // Grant selection: on a tie the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || lastGrant_r)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Last-granted pointer, advanced only when a grant is consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant_r <= 1'b1;
        end else if (update) begin
            lastGrant_r <= grant[1];
        end else begin
            lastGrant_r <= lastGrant_r;
        end
    end

endmodule

// File: rtl/y_row_sched.sv
// Y-row lookup scheduler. Arbitrates two row requesters, re-arms the
// y-address decoder, fetches the row word from SRAM, waits for the decoder
// (with timeout) and returns the address pair to a single consumer.
// Ports:
//   clock, reset                : clock, synchronous active-high reset
//   req0_*/req1_*               : valid/row in, one-cycle ready pulse out
//   dec_reset/rowNum/rowData    : decoder re-arm pulse and operands
//   dec_addr1/dec_addr2         : decoder results (11'h7FF = pending)
//   sram_readEn/Addr/Data       : single-word SRAM read port
//   resp_valid/id/addr1/addr2/err, resp_ready : response handshake
module y_row_sched
    import y_row_sched_pkg::*;
#(
    parameter int SRAM_LAT    = 1,
    parameter int DEC_TIMEOUT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [15:0]  req0_row,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [15:0]  req1_row,
    output logic         req1_ready,
    output logic         dec_reset,
    output logic [15:0]  dec_rowNum,
    output logic [255:0] dec_rowData,
    input  logic [10:0]  dec_addr1,
    input  logic [10:0]  dec_addr2,
    output logic         sram_readEn,
    output logic [10:0]  sram_readAddr,
    input  logic [255:0] sram_readData,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [10:0]  resp_addr1,
    output logic [10:0]  resp_addr2,
    output logic         resp_err,
    input  logic         resp_ready
);

    localparam int                WAIT_W    = $clog2(DEC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DEC_TIMEOUT - 1);
    localparam logic [2:0]        LAT_LAST  = 3'(SRAM_LAT);

    yState_e             state_r;
    logic [15:0]         rowLatch_r;
    logic                idLatch_r;
    logic [1:0]          reqReady_r;
    logic                decReset_r;
    logic [15:0]         decRowNum_r;
    logic [255:0]        decRowData_r;
    logic                sramEn_r;
    logic [10:0]         sramAddr_r;
    logic                respValid_r;
    logic                respId_r;
    logic [10:0]         respAddr1_r;
    logic [10:0]         respAddr2_r;
    logic                respErr_r;
    logic [2:0]          latCnt_r;
    logic                captured_r;
    logic [WAIT_W-1:0]   waitCnt_r;
    logic [1:0]          grant_s;
    logic                arbUpdate_s;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .update (arbUpdate_s),
        .grant  (grant_s)
    );

    // Pointer moves exactly when a request is granted out of IDLE.
    assign arbUpdate_s = (state_r == ST_IDLE) && (grant_s != 2'b00);

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rowLatch_r   <= 16'd0;
            idLatch_r    <= 1'b0;
            reqReady_r   <= 2'b00;
            decReset_r   <= 1'b0;
            decRowNum_r  <= 16'd0;
            decRowData_r <= 256'd0;
            sramEn_r     <= 1'b0;
            sramAddr_r   <= 11'd0;
            respValid_r  <= 1'b0;
            respId_r     <= 1'b0;
            respAddr1_r  <= ADDR_NONE;
            respAddr2_r  <= ADDR_NONE;
            respErr_r    <= 1'b0;
            latCnt_r     <= 3'd0;
            captured_r   <= 1'b0;
            waitCnt_r    <= '0;
        end else begin
            // Single-cycle strobes drop unless a state re-asserts them.
            reqReady_r <= 2'b00;
            decReset_r <= 1'b0;
            sramEn_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        reqReady_r <= grant_s;
                        rowLatch_r <= grant_s[1] ? req1_row : req0_row;
                        idLatch_r  <= grant_s[1];
                        state_r    <= ST_GRANT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (rowOutOfRange(rowLatch_r)) begin
                        respValid_r <= 1'b1;
                        respId_r    <= idLatch_r;
                        respErr_r   <= 1'b1;
                        respAddr1_r <= ADDR_NONE;
                        respAddr2_r <= ADDR_NONE;
                        state_r     <= ST_RESP;
                    end else begin
                        decReset_r  <= 1'b1;
                        decRowNum_r <= rowLatch_r;
                        state_r     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    sramEn_r   <= 1'b1;
                    sramAddr_r <= rowLatch_r[14:4];
                    state_r    <= ST_FETCH;
                end
                ST_FETCH: begin
                    // First WAITD cycle is already one cycle after the strobe.
                    latCnt_r   <= 3'd1;
                    captured_r <= 1'b0;
                    waitCnt_r  <= '0;
                    state_r    <= ST_WAITD;
                end
                ST_WAITD: begin
                    if (!captured_r) begin
                        if (latCnt_r == LAT_LAST) begin
                            decRowData_r <= sram_readData;
                            captured_r   <= 1'b1;
                        end else begin
                            latCnt_r     <= latCnt_r + 3'd1;
                        end
                    end else begin
                        captured_r <= 1'b1;
                    end
                    // Decoder outputs are stale until it has seen the new word.
                    if (captured_r && addrPairDone(dec_addr1, dec_addr2)) begin
                        respValid_r <= 1'b1;
                        respId_r    <= idLatch_r;
                        respErr_r   <= 1'b0;
                        respAddr1_r <= dec_addr1;
                        respAddr2_r <= dec_addr2;
                        state_r     <= ST_RESP;
                    end else if (waitCnt_r == WAIT_LAST) begin
                        respValid_r <= 1'b1;
                        respId_r    <= idLatch_r;
                        respErr_r   <= 1'b1;
                        respAddr1_r <= ADDR_NONE;
                        respAddr2_r <= ADDR_NONE;
                        state_r     <= ST_RESP;
                    end else begin
                        waitCnt_r   <= waitCnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        respValid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready    = reqReady_r[0];
    assign req1_ready    = reqReady_r[1];
    assign dec_reset     = decReset_r;
    assign dec_rowNum    = decRowNum_r;
    assign dec_rowData   = decRowData_r;
    assign sram_readEn   = sramEn_r;
    assign sram_readAddr = sramAddr_r;
    assign resp_valid    = respValid_r;
    assign resp_id       = respId_r;
    assign resp_addr1    = respAddr1_r;
    assign resp_addr2    = respAddr2_r;
    assign resp_err      = respErr_r;

endmodule

// File: tb/tb_y_row_sched.sv
// Directed bench for y_row_sched. Instance 0 uses SRAM_LAT=1/DEC_TIMEOUT=15,
// instance 1 uses SRAM_LAT=3/DEC_TIMEOUT=6. Each instance has an SRAM model
// (word a holds {x2,x1} with x1=a+11'h11D, x2=a+11'h11E; garbage outside the
// valid data cycle) and a decoder model that reports the captured word's
// fields once its data has arrived after re-arm, or 7FF when hung.
module tb_y_row_sched;

    localparam logic [255:0] GARBAGE = {8{32'hA5A5_0BAD}};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic [1:0]   req0Valid, req1Valid, req0Ready, req1Ready;
    logic [1:0]   decReset, sramEn, respValid, respId, respErr, respReady, decHang;
    logic [15:0]  req0Row [2];
    logic [15:0]  req1Row [2];
    logic [15:0]  decRowNum [2];
    logic [255:0] decRowData [2];
    logic [255:0] sramData [2];
    logic [10:0]  decAddr1 [2];
    logic [10:0]  decAddr2 [2];
    logic [10:0]  sramAddr [2];
    logic [10:0]  respAddr1 [2];
    logic [10:0]  respAddr2 [2];

    function automatic logic [255:0] sramWord(input logic [10:0] a);
        logic [10:0] x1;
        logic [10:0] x2;
        x1 = a + 11'h11D;
        x2 = a + 11'h11E;
        return {224'd0, 5'd0, x2, 5'd0, x1};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int TMO = (g == 0) ? 15 : 6;

        y_row_sched #(.SRAM_LAT(LAT), .DEC_TIMEOUT(TMO)) dut (
            .clock         (clock),
            .reset         (reset),
            .req0_valid    (req0Valid[g]),
            .req0_row      (req0Row[g]),
            .req0_ready    (req0Ready[g]),
            .req1_valid    (req1Valid[g]),
            .req1_row      (req1Row[g]),
            .req1_ready    (req1Ready[g]),
            .dec_reset     (decReset[g]),
            .dec_rowNum    (decRowNum[g]),
            .dec_rowData   (decRowData[g]),
            .dec_addr1     (decAddr1[g]),
            .dec_addr2     (decAddr2[g]),
            .sram_readEn   (sramEn[g]),
            .sram_readAddr (sramAddr[g]),
            .sram_readData (sramData[g]),
            .resp_valid    (respValid[g]),
            .resp_id       (respId[g]),
            .resp_addr1    (respAddr1[g]),
            .resp_addr2    (respAddr2[g]),
            .resp_err      (respErr[g]),
            .resp_ready    (respReady[g])
        );

        logic [3:0]  enPipe = 4'd0;
        logic [10:0] addrPipe [4];
        logic        decDone = 1'b0;

        // SRAM pipeline (not cleared by reset) and decoder completion flag.
        always @(posedge clock) begin
            enPipe      <= {enPipe[2:0], sramEn[g]};
            addrPipe[0] <= sramAddr[g];
            for (int i = 1; i < 4; i++) addrPipe[i] <= addrPipe[i-1];
            if (decReset[g]) decDone <= 1'b0;
            else if (enPipe[LAT-1]) decDone <= 1'b1;
        end

        assign sramData[g] = enPipe[LAT-1] ? sramWord(addrPipe[LAT-1]) : GARBAGE;
        assign decAddr1[g] = (decDone && !decHang[g]) ? decRowData[g][10:0]  : 11'h7FF;
        assign decAddr2[g] = (decDone && !decHang[g]) ? decRowData[g][26:16] : 11'h7FF;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  setMask;
        logic [15:0] row0;
        logic [15:0] row1;
        logic        hang;
        logic        expId;
        logic [10:0] expA1;
        logic [10:0] expA2;
        logic        expErr;
        int          expLat;
        int          expReads;
    } vec_t;

    // Serve one response; called and returning just after a negedge.
    task automatic runOne(input int g, input vec_t v, input string tag);
        int  c, acc, rsp, reads, arms;
        bit  gotAcc, gotRsp;
        if (v.setMask[0]) begin req0Row[g] = v.row0; req0Valid[g] = 1'b1; end
        if (v.setMask[1]) begin req1Row[g] = v.row1; req1Valid[g] = 1'b1; end
        decHang[g] = v.hang;
        respReady[g] = 1'b1;
        c = 0; acc = 0; rsp = 0; reads = 0; arms = 0; gotAcc = 0; gotRsp = 0;
        while (!gotRsp && c < 100) begin
            @(negedge clock);
            c++;
            if (sramEn[g]) reads++;
            if (decReset[g]) arms++;
            if (req0Ready[g] || req1Ready[g]) begin
                check({tag, " ready"}, 64'({req1Ready[g], req0Ready[g]}),
                      64'(v.expId ? 2'b10 : 2'b01));
                acc = c;
                gotAcc = 1;
                if (req0Ready[g]) req0Valid[g] = 1'b0;
                if (req1Ready[g]) req1Valid[g] = 1'b0;
            end
            if (respValid[g]) begin
                gotRsp = 1;
                rsp = c;
            end
        end
        check({tag, " accepted+responded"}, 64'(gotAcc && gotRsp), 64'(1));
        check({tag, " id"},    64'(respId[g]),    64'(v.expId));
        check({tag, " addr1"}, 64'(respAddr1[g]), 64'(v.expA1));
        check({tag, " addr2"}, 64'(respAddr2[g]), 64'(v.expA2));
        check({tag, " err"},   64'(respErr[g]),   64'(v.expErr));
        check({tag, " latency"}, 64'(rsp - acc), 64'(v.expLat));
        check({tag, " reads"}, 64'(reads), 64'(v.expReads));
        check({tag, " arms"},  64'(arms),  64'(v.expReads));
        @(negedge clock);
        check({tag, " resp dropped"}, 64'(respValid[g]), 64'(0));
    endtask

    task automatic checkResetState(input int g, input string tag);
        check({tag, " ready"}, 64'({req1Ready[g], req0Ready[g]}), 64'(0));
        check({tag, " strobes"}, 64'({respValid[g], sramEn[g], decReset[g]}), 64'(0));
        check({tag, " addrs"}, 64'({respAddr1[g], respAddr2[g]}), 64'({11'h7FF, 11'h7FF}));
        check({tag, " err/id"}, 64'({respErr[g], respId[g]}), 64'(0));
        check({tag, " rowNum"}, 64'(decRowNum[g]), 64'(0));
        check({tag, " rowData zero"}, 64'(decRowData[g] == 256'd0), 64'(1));
    endtask

    vec_t vecs [10];
    vec_t vLat3, vTmo3;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  seen;
        logic [26:0] held;

        //            mask   row0     row1     hang  id    a1       a2       err   lat reads
        vecs[0] = '{2'b11, 16'h0035, 16'h0207, 1'b0, 1'b0, 11'h120, 11'h121, 1'b0, 5,  1};
        vecs[1] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 11'h13D, 11'h13E, 1'b0, 5,  1};
        vecs[2] = '{2'b11, 16'h0100, 16'h0A50, 1'b0, 1'b0, 11'h12D, 11'h12E, 1'b0, 5,  1};
        vecs[3] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 11'h1C2, 11'h1C3, 1'b0, 5,  1};
        vecs[4] = '{2'b10, 16'h0000, 16'h7FF0, 1'b0, 1'b1, 11'h7FF, 11'h7FF, 1'b1, 1,  0};
        vecs[5] = '{2'b01, 16'h7FEF, 16'h0000, 1'b0, 1'b0, 11'h11B, 11'h11C, 1'b0, 5,  1};
        vecs[6] = '{2'b01, 16'h8000, 16'h0000, 1'b0, 1'b0, 11'h7FF, 11'h7FF, 1'b1, 1,  0};
        vecs[7] = '{2'b01, 16'h0035, 16'h0000, 1'b1, 1'b0, 11'h7FF, 11'h7FF, 1'b1, 18, 1};
        vecs[8] = '{2'b11, 16'h0010, 16'h0020, 1'b0, 1'b1, 11'h11F, 11'h120, 1'b0, 5,  1};
        vecs[9] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 11'h11E, 11'h11F, 1'b0, 5,  1};
        vLat3   = '{2'b01, 16'h0035, 16'h0000, 1'b0, 1'b0, 11'h120, 11'h121, 1'b0, 7,  1};
        vTmo3   = '{2'b01, 16'h0035, 16'h0000, 1'b1, 1'b0, 11'h7FF, 11'h7FF, 1'b1, 9,  1};

        reset = 1'b1;
        req0Valid = 2'b00; req1Valid = 2'b00; respReady = 2'b00; decHang = 2'b00;
        for (int i = 0; i < 2; i++) begin req0Row[i] = 16'd0; req1Row[i] = 16'd0; end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkResetState(0, "reset0");
        checkResetState(1, "reset1");

        for (int i = 0; i < 10; i++) runOne(0, vecs[i], $sformatf("vec%0d", i));

        // Response stall: fields stable, pending requester not readied.
        req0Row[0] = 16'h0035; req0Valid[0] = 1'b1; respReady[0] = 1'b0; decHang[0] = 1'b0;
        c = 0; seen = 0;
        while (!seen && c < 20) begin
            @(negedge clock); c++;
            if (req0Ready[0]) begin
                seen = 1; req0Valid[0] = 1'b0;
                req1Row[0] = 16'h0010; req1Valid[0] = 1'b1;
            end
        end
        check("stall accept", 64'(seen), 64'(1));
        c = 0;
        while (!respValid[0] && c < 20) begin @(negedge clock); c++; end
        for (int i = 0; i < 10; i++) begin
            held = {respValid[0], respId[0], respErr[0], respAddr1[0], respAddr2[0],
                    req1Ready[0], req0Ready[0]};
            check($sformatf("stall hold %0d", i), 64'(held),
                  64'({1'b1, 1'b0, 1'b0, 11'h120, 11'h121, 1'b0, 1'b0}));
            @(negedge clock);
        end
        respReady[0] = 1'b1;
        @(negedge clock);
        check("handshake cycle", 64'({respValid[0], req1Ready[0], req0Ready[0]}), 64'(0));
        @(negedge clock);
        check("accept after idle", 64'({req1Ready[0], req0Ready[0]}), 64'(2'b10));
        req1Valid[0] = 1'b0;
        c = 0;
        while (!respValid[0] && c < 20) begin @(negedge clock); c++; end
        check("stall next resp", 64'({respValid[0], respId[0], respAddr1[0], respAddr2[0]}),
              64'({1'b1, 1'b1, 11'h11E, 11'h11F}));
        @(negedge clock);

        // Reset in FETCH: request abandoned, late SRAM data ignored.
        req0Row[0] = 16'h0035; req0Valid[0] = 1'b1; respReady[0] = 1'b1;
        c = 0; seen = 0;
        while (!seen && c < 20) begin
            @(negedge clock); c++;
            if (req0Ready[0]) req0Valid[0] = 1'b0;
            if (sramEn[0]) seen = 1;
        end
        check("reached fetch", 64'(seen), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkResetState(0, "midreset");
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (respValid[0] || sramEn[0] || decRowData[0] != 256'd0) seen = 1;
        end
        check("no resp after reset", 64'(seen), 64'(0));

        // Longer SRAM latency and shorter timeout on instance 1.
        runOne(1, vLat3, "lat3");
        runOne(1, vTmo3, "tmo6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
